// File: rtl/mshr_fill_ctrl.sv
// Four-entry miss-status holding registers: allocate on miss, issue line read to L2, capture fill, write back to cache.
// Latency: alloc -> l2_req next cycle; l2 response -> fill_valid next cycle.
// Backpressure: l2_req and fill hold their selected entry until ready; alloc is dropped when full or duplicate.
module mshr_fill_ctrl #(
    parameter int          ADDR_W = 32,
    parameter int          LINE_W = 128,
    parameter int          OFF_W  = 4,
    parameter logic [3:0]  ST_S   = 4'h1,
    parameter logic [3:0]  ST_M   = 4'h2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [3:0]        alloc_way,
    input  logic [2:0]        alloc_op,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              mshr_hit,
    output logic              mshr_full,
    output logic              l2_req_valid,
    input  logic              l2_req_ready,
    output logic [2:0]        l2_req_op,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [1:0]        l2_req_id,
    input  logic              l2_resp_valid,
    input  logic [1:0]        l2_resp_id,
    input  logic [LINE_W-1:0] l2_resp_data,
    output logic              resp_err,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [3:0]        fill_way,
    output logic [LINE_W-1:0] fill_data,
    output logic [3:0]        fill_state
);

    typedef enum logic [1:0] {E_FREE, E_REQ, E_WAIT, E_FILL} ent_state_e;

    localparam int TAG_W = ADDR_W - OFF_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{TAG_W{1'b1}}, {OFF_W{1'b0}}};
    localparam logic [2:0] OP_ST    = 3'd2;
    localparam logic [2:0] OP_RD    = 3'd3;
    localparam logic [2:0] OP_RWITM = 3'd7;

    ent_state_e        state_q [4];
    ent_state_e        state_d [4];
    logic [ADDR_W-1:0] addr_q  [4];
    logic [ADDR_W-1:0] addr_d  [4];
    logic [3:0]        way_q   [4];
    logic [3:0]        way_d   [4];
    logic [2:0]        op_q    [4];
    logic [2:0]        op_d    [4];
    logic [LINE_W-1:0] data_q  [4];
    logic [LINE_W-1:0] data_d  [4];

    logic       full_q, full_d;
    logic       resp_err_q, resp_err_d;
    logic       req_lock_q, req_lock_d;
    logic [1:0] req_lock_id_q, req_lock_id_d;
    logic       fill_lock_q, fill_lock_d;
    logic [1:0] fill_lock_id_q, fill_lock_id_d;

    logic       alloc_match, free_found, alloc_ok;
    logic [1:0] free_idx;
    logic       req_any, fill_any;
    logic [1:0] req_low, fill_low, req_sel, fill_sel;
    logic       lookup_hit;

    // Lowest-index searches and line matches, all from registered state.
    always_comb begin
        alloc_match = 1'b0;
        lookup_hit  = 1'b0;
        free_found  = 1'b0;
        free_idx    = 2'd0;
        req_any     = 1'b0;
        req_low     = 2'd0;
        fill_any    = 1'b0;
        fill_low    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (state_q[i] != E_FREE) begin
                if (addr_q[i][ADDR_W-1:OFF_W] == alloc_addr[ADDR_W-1:OFF_W])  alloc_match = 1'b1;
                if (addr_q[i][ADDR_W-1:OFF_W] == lookup_addr[ADDR_W-1:OFF_W]) lookup_hit  = 1'b1;
            end
            if (state_q[i] == E_FREE) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
            if (state_q[i] == E_REQ) begin
                req_any = 1'b1;
                req_low = 2'(i);
            end
            if (state_q[i] == E_FILL) begin
                fill_any = 1'b1;
                fill_low = 2'(i);
            end
        end
    end

    assign alloc_ok = alloc_valid && !full_q && !alloc_match && free_found;

    // A stalled handshake stays pinned to its entry even if a lower index becomes eligible.
    assign req_sel      = req_lock_q  ? req_lock_id_q  : req_low;
    assign fill_sel     = fill_lock_q ? fill_lock_id_q : fill_low;
    assign l2_req_valid = req_lock_q  || req_any;
    assign fill_valid   = fill_lock_q || fill_any;

    assign l2_req_op   = (op_q[req_sel] == OP_ST) ? OP_RWITM : OP_RD;
    assign l2_req_addr = addr_q[req_sel] & LINE_MASK;
    assign l2_req_id   = req_sel;

    assign fill_addr  = addr_q[fill_sel] & LINE_MASK;
    assign fill_way   = way_q[fill_sel];
    assign fill_data  = data_q[fill_sel];
    assign fill_state = (op_q[fill_sel] == OP_ST) ? ST_M : ST_S;

    assign mshr_hit  = lookup_hit;
    assign mshr_full = full_q;
    assign resp_err  = resp_err_q;

    always_comb begin
        full_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            way_d[i]   = way_q[i];
            op_d[i]    = op_q[i];
            data_d[i]  = data_q[i];
            if (alloc_ok && free_idx == 2'(i)) begin
                state_d[i] = E_REQ;
                addr_d[i]  = alloc_addr;
                way_d[i]   = alloc_way;
                op_d[i]    = alloc_op;
            end
            if (l2_req_valid && l2_req_ready && req_sel == 2'(i)) state_d[i] = E_WAIT;
            if (l2_resp_valid && l2_resp_id == 2'(i) && state_q[i] == E_WAIT) begin
                state_d[i] = E_FILL;
                data_d[i]  = l2_resp_data;
            end
            if (fill_valid && fill_ready && fill_sel == 2'(i)) state_d[i] = E_FREE;
            if (state_d[i] == E_FREE) full_d = 1'b0;
        end
        resp_err_d     = l2_resp_valid && (state_q[l2_resp_id] != E_WAIT);
        req_lock_d     = l2_req_valid && !l2_req_ready;
        req_lock_id_d  = req_sel;
        fill_lock_d    = fill_valid && !fill_ready;
        fill_lock_id_d = fill_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) state_q[i] <= E_FREE;
            full_q         <= 1'b0;
            resp_err_q     <= 1'b0;
            req_lock_q     <= 1'b0;
            req_lock_id_q  <= 2'd0;
            fill_lock_q    <= 1'b0;
            fill_lock_id_q <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
            full_q         <= full_d;
            resp_err_q     <= resp_err_d;
            req_lock_q     <= req_lock_d;
            req_lock_id_q  <= req_lock_id_d;
            fill_lock_q    <= fill_lock_d;
            fill_lock_id_q <= fill_lock_id_d;
        end
    end

    // Payload registers are qualified by state, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            addr_q[i] <= addr_d[i];
            way_q[i]  <= way_d[i];
            op_q[i]   <= op_d[i];
            data_q[i] <= data_d[i];
        end
    end

endmodule

// File: tb/tb_mshr_fill_ctrl.sv
// Directed bench for mshr_fill_ctrl: single LD/ST flows, full/duplicate filtering, bad responses, mid-flight reset.
module tb_mshr_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_valid;
    logic [31:0]  alloc_addr;
    logic [3:0]   alloc_way;
    logic [2:0]   alloc_op;
    logic [31:0]  lookup_addr;
    logic         mshr_hit, mshr_full;
    logic         l2_req_valid, l2_req_ready;
    logic [2:0]   l2_req_op;
    logic [31:0]  l2_req_addr;
    logic [1:0]   l2_req_id;
    logic         l2_resp_valid;
    logic [1:0]   l2_resp_id;
    logic [127:0] l2_resp_data;
    logic         resp_err;
    logic         fill_valid, fill_ready;
    logic [31:0]  fill_addr;
    logic [3:0]   fill_way;
    logic [127:0] fill_data;
    logic [3:0]   fill_state;

    int passed = 0;
    int total  = 0;

    localparam logic [127:0] DATA_A = {16{8'hA5}};
    localparam logic [127:0] DATA_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    mshr_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_way(alloc_way), .alloc_op(alloc_op),
        .lookup_addr(lookup_addr), .mshr_hit(mshr_hit), .mshr_full(mshr_full),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_op(l2_req_op),
        .l2_req_addr(l2_req_addr), .l2_req_id(l2_req_id),
        .l2_resp_valid(l2_resp_valid), .l2_resp_id(l2_resp_id), .l2_resp_data(l2_resp_data),
        .resp_err(resp_err),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_way(fill_way),
        .fill_data(fill_data), .fill_state(fill_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [31:0] a, input logic [3:0] w, input logic [2:0] op);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        alloc_way   = w;
        alloc_op    = op;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic respond(input logic [1:0] id, input logic [127:0] d);
        l2_resp_valid = 1'b1;
        l2_resp_id    = id;
        l2_resp_data  = d;
        step();
        l2_resp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_addr = '0; alloc_way = '0; alloc_op = '0;
        lookup_addr = '0; l2_req_ready = 1'b0;
        l2_resp_valid = 1'b0; l2_resp_id = '0; l2_resp_data = '0; fill_ready = 1'b0;
        step(); step();
        chk("rst_l2_req_valid", l2_req_valid, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_full", mshr_full, 0);
        chk("rst_hit", mshr_hit, 0);
        chk("rst_resp_err", resp_err, 0);
        rst_n = 1'b1;
        step();

        // LD flow
        l2_req_ready = 1'b1;
        alloc(32'h1000, 4'b0010, 3'd1);
        chk("ld_req_valid", l2_req_valid, 1);
        chk("ld_req_op", l2_req_op, 3);
        chk("ld_req_addr", l2_req_addr, 32'h1000);
        chk("ld_req_id", l2_req_id, 0);
        step();
        chk("ld_req_done", l2_req_valid, 0);
        lookup_addr = 32'h100C;
        #1;
        chk("ld_hit_wait", mshr_hit, 1);
        alloc(32'h1008, 4'b0001, 3'd1);
        chk("dup_alloc_no_req", l2_req_valid, 0);
        respond(2'd0, DATA_A);
        chk("ld_fill_valid", fill_valid, 1);
        chk("ld_fill_way", fill_way, 4'b0010);
        chk("ld_fill_state", fill_state, 4'h1);
        chk("ld_fill_data", fill_data, DATA_A);
        chk("ld_fill_addr", fill_addr, 32'h1000);
        chk("ld_no_err", resp_err, 0);
        step();
        chk("ld_fill_held", fill_valid, 1);
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;
        chk("ld_fill_done", fill_valid, 0);
        chk("ld_freed_hit", mshr_hit, 0);

        // ST flow
        alloc(32'h2004, 4'b0100, 3'd2);
        chk("st_req_op", l2_req_op, 7);
        chk("st_req_addr", l2_req_addr, 32'h2000);
        step();
        respond(2'd0, DATA_B);
        chk("st_fill_state", fill_state, 4'h2);
        chk("st_fill_addr", fill_addr, 32'h2000);
        chk("st_fill_data", fill_data, DATA_B);
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;
        chk("st_fill_done", fill_valid, 0);

        // Response to a FREE entry
        respond(2'd2, DATA_A);
        chk("bad_resp_err", resp_err, 1);
        chk("bad_resp_no_fill", fill_valid, 0);
        step();
        chk("bad_resp_pulse_end", resp_err, 0);

        // Fill all four entries with L2 stalled
        l2_req_ready = 1'b0;
        alloc(32'h100, 4'b0001, 3'd1);
        chk("part_not_full", mshr_full, 0);
        alloc(32'h200, 4'b0010, 3'd1);
        alloc(32'h300, 4'b0100, 3'd1);
        alloc(32'h400, 4'b1000, 3'd1);
        chk("full_set", mshr_full, 1);
        chk("full_req_id", l2_req_id, 0);
        alloc(32'h500, 4'b0001, 3'd1);
        lookup_addr = 32'h500;
        #1;
        chk("fifth_ignored_hit", mshr_hit, 0);
        chk("full_held", mshr_full, 1);
        chk("stall_req_valid", l2_req_valid, 1);
        chk("stall_req_id", l2_req_id, 0);
        chk("stall_req_addr", l2_req_addr, 32'h100);
        chk("stall_req_op", l2_req_op, 3);
        l2_req_ready = 1'b1;
        step();
        chk("drain_next_id", l2_req_id, 1);
        chk("drain_next_addr", l2_req_addr, 32'h200);
        step(); step(); step();
        l2_req_ready = 1'b0;
        chk("drain_done", l2_req_valid, 0);
        chk("drain_still_full", mshr_full, 1);

        // Reset with all entries in WAIT
        lookup_addr = 32'h100;
        rst_n = 1'b0;
        #1;
        chk("midrst_full", mshr_full, 0);
        chk("midrst_hit", mshr_hit, 0);
        chk("midrst_req_valid", l2_req_valid, 0);
        chk("midrst_fill_valid", fill_valid, 0);
        chk("midrst_resp_err", resp_err, 0);
        step();
        rst_n = 1'b1;
        step();
        respond(2'd0, DATA_A);
        chk("post_rst_resp_err", resp_err, 1);
        chk("post_rst_no_fill", fill_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
